// File: rtl/upg_loader.sv
// UART program loader: takes a word-count header and then little-endian 32-bit words
// from a byte stream, and writes them to instruction memory one word per pulse.
module upg_loader #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_WORDS      = 16384
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        upg_rst_o,
    output logic        upg_wen_o,
    output logic [13:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        busy_o,
    output logic        error_o
);

    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] MAX_W    = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   n_q, n_d;
    logic [14:0]   word_q, word_d;
    logic [1:0]    byte_q, byte_d;
    logic [23:0]   asm_q, asm_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          wen_q, wen_d;
    logic [13:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          rst_q, rst_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic          loading_s;
    logic          start_acc_s;
    logic          byte_acc_s;
    logic          tmo_hit_s;
    logic [15:0]   hdr_n_s;
    logic [15:0]   word_next_s;

    assign loading_s   = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA);
    assign start_acc_s = start_i && !loading_s;
    assign byte_acc_s  = rx_valid_i && loading_s && !start_acc_s;
    assign tmo_hit_s   = (tmo_q == TMO_LAST);
    assign hdr_n_s     = {rx_data_i, n_q[7:0]};
    assign word_next_s = {1'b0, word_q} + 16'd1;

    // Next-state, datapath updates and decoded output flags (registered below).
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        word_d  = word_q;
        byte_d  = byte_q;
        asm_d   = asm_q;
        tmo_d   = tmo_q;
        wen_d   = 1'b0;
        adr_d   = adr_q;
        dat_d   = dat_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_acc_s) begin
                    state_d = S_HDR0;
                    tmo_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_HDR0: begin
                if (byte_acc_s) begin
                    n_d[7:0] = rx_data_i;
                    tmo_d    = '0;
                    state_d  = S_HDR1;
                end else if (tmo_hit_s) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_HDR1: begin
                if (byte_acc_s) begin
                    n_d   = hdr_n_s;
                    tmo_d = '0;
                    if (hdr_n_s == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, hdr_n_s} > MAX_W) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                        word_d  = 15'd0;
                        byte_d  = 2'd0;
                    end
                end else if (tmo_hit_s) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DATA: begin
                if (byte_acc_s) begin
                    tmo_d  = '0;
                    byte_d = byte_q + 2'd1;
                    case (byte_q)
                        2'd0: asm_d[7:0]   = rx_data_i;
                        2'd1: asm_d[15:8]  = rx_data_i;
                        2'd2: asm_d[23:16] = rx_data_i;
                        2'd3: begin
                            // Last byte goes straight to the output word; no need to stage it.
                            wen_d  = 1'b1;
                            adr_d  = word_q[13:0];
                            dat_d  = {rx_data_i, asm_q};
                            word_d = word_q + 15'd1;
                            if (word_next_s == n_q) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_DATA;
                            end
                        end
                        default: asm_d = asm_q;
                    endcase
                end else if (tmo_hit_s) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        rst_d  = 1'b0;
        done_d = 1'b0;
        busy_d = 1'b0;
        err_d  = 1'b0;
        case (state_d)
            S_IDLE:                 rst_d  = 1'b1;
            S_HDR0, S_HDR1, S_DATA: busy_d = 1'b1;
            S_DONE:                 done_d = 1'b1;
            S_ERR: begin
                rst_d = 1'b1;
                err_d = 1'b1;
            end
            default:                rst_d  = 1'b1;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            n_q     <= 16'd0;
            word_q  <= 15'd0;
            byte_q  <= 2'd0;
            asm_q   <= 24'd0;
            tmo_q   <= '0;
            wen_q   <= 1'b0;
            adr_q   <= 14'd0;
            dat_q   <= 32'd0;
            rst_q   <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            asm_q   <= asm_d;
            tmo_q   <= tmo_d;
            wen_q   <= wen_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign upg_rst_o  = rst_q;
    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;
    assign busy_o     = busy_q;
    assign error_o    = err_q;

endmodule

// File: tb/tb_upg_loader.sv
// Randomized bench for upg_loader; expected memory writes come from a word-list model.
module tb_upg_loader;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = 8'd0;
    logic        upg_rst_o, upg_wen_o, upg_done_o, busy_o, error_o;
    logic [13:0] upg_adr_o;
    logic [31:0] upg_dat_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    logic [45:0] exp_q [$];
    logic [45:0] exp_e;

    upg_loader #(.TIMEOUT_CYCLES(16), .MAX_WORDS(16384)) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .start_i    (start_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .upg_rst_o  (upg_rst_o),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .busy_o     (busy_o),
        .error_o    (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every write pulse must match the next entry of the expected-write list.
    always @(negedge clk_i) begin
        if (upg_wen_o === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("unexpected_wen", 32'd1, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_adr", {18'd0, upg_adr_o}, {18'd0, exp_e[45:32]});
                check("wr_dat", upg_dat_o, exp_e[31:0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        cyc();
        rx_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
    endtask

    task automatic gap(input int mx);
        repeat ($urandom_range(0, mx)) cyc();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rst"},  {31'd0, upg_rst_o},  32'd1);
        check({tag, "_wen"},  {31'd0, upg_wen_o},  32'd0);
        check({tag, "_adr"},  {18'd0, upg_adr_o},  32'd0);
        check({tag, "_dat"},  upg_dat_o,           32'd0);
        check({tag, "_done"}, {31'd0, upg_done_o}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_o},     32'd0);
        check({tag, "_err"},  {31'd0, error_o},    32'd0);
    endtask

    // Full load of ws: start, header, data bytes LSB first, with optional stray start mid-data.
    task automatic run_stream(input logic [31:0] ws [$], input bit mid_start, input bit do_start);
        int n;
        logic [31:0] w;
        n = ws.size();
        for (int i = 0; i < n; i++) begin
            w = ws[i];
            exp_q.push_back({i[13:0], w});
        end
        if (do_start) pulse_start();
        gap(4);
        send_byte(n[7:0]);
        gap(4);
        send_byte(n[15:8]);
        for (int i = 0; i < n; i++) begin
            w = ws[i];
            for (int k = 0; k < 4; k++) begin
                gap(4);
                if (mid_start && i == n / 2 && k == 2) pulse_start();
                send_byte(w[8*k +: 8]);
            end
        end
        check("ld_wen_now", {31'd0, upg_wen_o}, 32'd1);
        check("ld_done", {31'd0, upg_done_o}, 32'd1);
        check("ld_busy", {31'd0, busy_o}, 32'd0);
        cyc();
        check("ld_pending", exp_q.size(), 32'd0);
        check("ld_err", {31'd0, error_o}, 32'd0);
        check("ld_rst", {31'd0, upg_rst_o}, 32'd0);
        check("hold_adr", {18'd0, upg_adr_o}, n - 1);
        check("hold_dat", upg_dat_o, ws[n-1]);
    endtask

    initial begin
        logic [31:0] ws [$];
        int wr_before;

        repeat (2) cyc();
        check_reset_vals("reset");
        reset_n_i = 1'b1;
        cyc();
        send_byte(8'h55);
        check("idle_rx_busy", {31'd0, busy_o}, 32'd0);
        check("idle_rx_rst", {31'd0, upg_rst_o}, 32'd1);

        // Reference two-word load.
        ws = '{32'h12345678, 32'hDEADBEEF};
        run_stream(ws, 1'b0, 1'b1);

        // Byte while DONE is ignored.
        send_byte(8'hA5);
        cyc();
        check("done_rx_hold", {31'd0, upg_done_o}, 32'd1);

        // Empty load.
        wr_before = n_wr;
        pulse_start();
        check("hdr0_busy", {31'd0, busy_o}, 32'd1);
        check("hdr0_done_clr", {31'd0, upg_done_o}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h00);
        check("n0_done", {31'd0, upg_done_o}, 32'd1);
        check("n0_busy", {31'd0, busy_o}, 32'd0);
        cyc();
        check("n0_nowrite", n_wr - wr_before, 32'd0);

        // Over-size header.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h40);
        check("big_err", {31'd0, error_o}, 32'd1);
        check("big_rst", {31'd0, upg_rst_o}, 32'd1);
        check("big_done", {31'd0, upg_done_o}, 32'd0);
        check("big_busy", {31'd0, busy_o}, 32'd0);
        cyc();
        check("big_nowrite", n_wr - wr_before, 32'd0);

        // N equal to the maximum is accepted; abandon it with reset.
        pulse_start();
        check("restart_err_clr", {31'd0, error_o}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h40);
        check("max_busy", {31'd0, busy_o}, 32'd1);
        check("max_err", {31'd0, error_o}, 32'd0);
        reset_n_i = 1'b0;
        cyc();
        reset_n_i = 1'b1;

        // Timeout after a partial word.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        repeat (15) cyc();
        check("tmo_not_yet", {31'd0, error_o}, 32'd0);
        check("tmo_busy", {31'd0, busy_o}, 32'd1);
        cyc();
        check("tmo_err", {31'd0, error_o}, 32'd1);
        check("tmo_rst", {31'd0, upg_rst_o}, 32'd1);
        repeat (3) cyc();
        check("tmo_nowrite", n_wr - wr_before, 32'd0);

        // Reset in the middle of a word, then a fresh load starts at address 0.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        reset_n_i = 1'b0;
        cyc();
        reset_n_i = 1'b1;
        check_reset_vals("midrst");
        send_byte(8'h33);
        send_byte(8'h44);
        cyc();
        check("midrst_nowrite", n_wr - wr_before, 32'd0);
        check("midrst_idle", {31'd0, busy_o}, 32'd0);
        ws = '{32'hCAFEF00D};
        run_stream(ws, 1'b0, 1'b1);

        // Stray start mid-data, then start together with a byte while DONE.
        ws = '{};
        for (int i = 0; i < 4; i++) ws.push_back($urandom);
        run_stream(ws, 1'b1, 1'b1);
        start_i    = 1'b1;
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h03;
        cyc();
        start_i    = 1'b0;
        rx_valid_i = 1'b0;
        check("start_byte_busy", {31'd0, busy_o}, 32'd1);
        ws = '{};
        for (int i = 0; i < 2; i++) ws.push_back($urandom);
        run_stream(ws, 1'b0, 1'b0);

        // Random loads.
        for (int t = 0; t < 6; t++) begin
            ws = '{};
            for (int i = 0; i < int'($urandom_range(1, 7)); i++) ws.push_back($urandom);
            run_stream(ws, t[0], 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
